// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor.
//   bp_entry_t : one BTB entry (valid, tag, word-aligned target, 2-bit counter)
//   ctr_t      : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   ctr_next() : saturating counter update
//   pc_tag()   : tag extraction, zero-extended to the widest possible tag
package bp_pkg;

  // Widest tag occurs at the smallest table (4 entries): PC[31:4] -> 28 bits;
  // 30 bits keeps the struct fixed-width for every legal ENTRIES.
  localparam int TAG_W = 30;
  localparam int TGT_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
    ctr_t             ctr;
  } bp_entry_t;

  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return TAG_W'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/bp_table.sv
// bp_table: ENTRIES-deep BTB storage.
//   clk, rst_n            : clock, async active-low reset (valid=0, counter=WNT)
//   rd_idx / rd_entry     : combinational read port (returns pre-write contents)
//   wr_upd                : resolve a branch at wr_idx (hit: count/retarget; miss+taken: allocate)
//   wr_inv                : clear the valid bit at wr_idx (alias)
//   wr_tag, wr_taken, wr_target : resolved branch tag, outcome, target[31:2]
// The write port is read-modify-write on its own index so a back-to-back
// branch always updates the current counter, not one sampled at fetch.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_entry_t        rd_entry,
  input  logic             wr_upd,
  input  logic             wr_inv,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [TGT_W-1:0] wr_target
);

  bp_entry_t mem_r [ENTRIES];
  logic      wr_hit_s;

  assign rd_entry = mem_r[rd_idx];
  assign wr_hit_s = mem_r[wr_idx].valid && (mem_r[wr_idx].tag == wr_tag);

  // Entry storage: reset, alias invalidation, counter update or allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_r[i] <= '{valid: 1'b0, tag: {TAG_W{1'b0}}, target: {TGT_W{1'b0}}, ctr: WNT};
      end
    end else if (wr_inv) begin
      mem_r[wr_idx].valid <= 1'b0;
    end else if (wr_upd) begin
      if (wr_hit_s) begin
        mem_r[wr_idx].ctr <= ctr_next(mem_r[wr_idx].ctr, wr_taken);
        if (wr_taken) begin
          mem_r[wr_idx].target <= wr_target;
        end
      end else if (wr_taken) begin
        mem_r[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: WT};
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + 2-bit counter predictor with decode-stage resolution.
//   Fetch : PCF -> PredTakenF, PredTargetF (combinational lookup)
//   Decode: StallD/FlushD control the IdxD/PredTakenD/PredTargetD registers;
//           BranchD/BranchTakenD/BranchTargetD/PCPlus4D resolve the branch and
//           drive MispredictD/RedirectPCD; BranchCnt/MispredCnt are statistics.
// Optional feature: define BP_GSHARE_EN to XOR a HIST_BITS-wide global history
// into the fetch index (gshare). Default build uses plain PC indexing.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int HIST_BITS = 4
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        BranchD,
  input  logic        BranchTakenD,
  input  logic [31:0] BranchTargetD,
  input  logic [31:0] PCPlus4D,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  output logic        MispredictD,
  output logic [31:0] RedirectPCD,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  if ((ENTRIES < 4) || (ENTRIES > 256) || ((ENTRIES & (ENTRIES - 1)) != 0) ||
      (HIST_BITS < 1) || (HIST_BITS > IDX_W)) begin : g_bad_cfg
    $error("branch_predictor: ENTRIES or HIST_BITS out of range");
  end

  logic [IDX_W-1:0] idx_f_s;
  logic [IDX_W-1:0] idx_d_r;
  logic             pred_taken_d_r;
  logic [31:0]      pred_target_d_r;
  bp_entry_t        rd_entry_s;
  logic             upd_s;
  logic             alias_s;
  logic [31:0]      pc_d_s;

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_r;

  assign idx_f_s = PCF[IDX_W+1:2] ^ IDX_W'(ghr_r);

  // Global history: newest outcome enters at bit 0, oldest falls off the top.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ghr_r <= {HIST_BITS{1'b0}};
    end else if (upd_s) begin
      ghr_r <= HIST_BITS'({ghr_r, BranchTakenD});
    end
  end
`else
  assign idx_f_s = PCF[IDX_W+1:2];
`endif

  bp_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk       (CLK),
    .rst_n     (rst_n),
    .rd_idx    (idx_f_s),
    .rd_entry  (rd_entry_s),
    .wr_upd    (upd_s),
    .wr_inv    (alias_s),
    .wr_idx    (idx_d_r),
    .wr_tag    (pc_tag(pc_d_s, IDX_W)),
    .wr_taken  (BranchTakenD),
    .wr_target (BranchTargetD[31:2])
  );

  // Fetch-stage lookup.
  always_comb begin
    PredTakenF = rd_entry_s.valid && (rd_entry_s.tag == pc_tag(PCF, IDX_W)) && rd_entry_s.ctr[1];
    if (PredTakenF) begin
      PredTargetF = {rd_entry_s.target, 2'b00};
    end else begin
      PredTargetF = PCF + 32'd4;
    end
  end

  // Decode-stage resolution. The update always uses the registered index so
  // a history change between fetch and decode cannot redirect the write.
  always_comb begin
    pc_d_s  = PCPlus4D - 32'd4;
    upd_s   = BranchD && !StallD;
    alias_s = !BranchD && pred_taken_d_r && !StallD;
    // rst_n gate keeps the redirect quiet while the pipeline is held in reset.
    MispredictD = rst_n && !StallD &&
                  ((BranchD && (pred_taken_d_r != BranchTakenD)) ||
                   (BranchD && BranchTakenD && (pred_target_d_r != BranchTargetD)) ||
                   (!BranchD && pred_taken_d_r));
    if (BranchD && BranchTakenD) begin
      RedirectPCD = BranchTargetD;
    end else begin
      RedirectPCD = PCPlus4D;
    end
  end

  // IF/ID prediction registers; flush wins over stall.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      idx_d_r         <= {IDX_W{1'b0}};
      pred_taken_d_r  <= 1'b0;
      pred_target_d_r <= 32'd0;
    end else if (FlushD) begin
      idx_d_r         <= {IDX_W{1'b0}};
      pred_taken_d_r  <= 1'b0;
      pred_target_d_r <= 32'd0;
    end else if (!StallD) begin
      idx_d_r         <= idx_f_s;
      pred_taken_d_r  <= PredTakenF;
      pred_target_d_r <= PredTargetF;
    end
  end

  // Statistics counters, free-running modulo 2^32.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      BranchCnt  <= 32'd0;
      MispredCnt <= 32'd0;
    end else begin
      if (upd_s) begin
        BranchCnt <= BranchCnt + 32'd1;
      end
      if (MispredictD) begin
        MispredCnt <= MispredCnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
// (ENTRIES=16, HIST_BITS=4). Default build walks allocate/hit, counter
// saturation, stall/flush, aliasing and mid-run reset; with BP_GSHARE_EN
// it instead trains an alternating branch and expects mispredictions to stop.
module tb_branch_predictor;

  logic        CLK;
  logic        rst_n;
  logic [31:0] PCF;
  logic        StallD;
  logic        FlushD;
  logic        BranchD;
  logic        BranchTakenD;
  logic [31:0] BranchTargetD;
  logic [31:0] PCPlus4D;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        MispredictD;
  logic [31:0] RedirectPCD;
  logic [31:0] BranchCnt;
  logic [31:0] MispredCnt;

  int tests = 0;
  int fails = 0;

  branch_predictor #(.ENTRIES(16), .HIST_BITS(4)) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .PCF           (PCF),
    .StallD        (StallD),
    .FlushD        (FlushD),
    .BranchD       (BranchD),
    .BranchTakenD  (BranchTakenD),
    .BranchTargetD (BranchTargetD),
    .PCPlus4D      (PCPlus4D),
    .PredTakenF    (PredTakenF),
    .PredTargetF   (PredTargetF),
    .MispredictD   (MispredictD),
    .RedirectPCD   (RedirectPCD),
    .BranchCnt     (BranchCnt),
    .MispredCnt    (MispredCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic br, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] pc4, input logic [31:0] pcf);
    BranchD       = br;
    BranchTakenD  = tk;
    BranchTargetD = tgt;
    PCPlus4D      = pc4;
    PCF           = pcf;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    BranchD = 1'b1; BranchTakenD = 1'b1; BranchTargetD = 32'h100;
    PCPlus4D = 32'h44; PCF = 32'h40;
    #2;
    chk("rst_pred_taken", {31'd0, PredTakenF}, 32'd0);
    chk("rst_pred_target", PredTargetF, 32'h44);
    chk("rst_mispredict", {31'd0, MispredictD}, 32'd0);
    chk("rst_branch_cnt", BranchCnt, 32'd0);
    chk("rst_mispred_cnt", MispredCnt, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

`ifdef BP_GSHARE_EN
    // Alternating T/N at 0x80; fetch and resolve in separate cycles so the
    // history is current at each fetch. Filler PC 0x200 never allocates.
    for (int k = 0; k < 20; k++) begin
      drv(1'b0, 1'b0, 32'h0, 32'h204, 32'h80);
      tick();
      drv(1'b1, (k % 2) == 0, 32'h300, 32'h84, 32'h200);
      tick();
      if (k == 9) chk("gs_mcnt_warm", MispredCnt, 32'd3);
    end
    chk("gs_mcnt_steady", MispredCnt, 32'd3);
    chk("gs_bcnt", BranchCnt, 32'd20);
`else
    // Cold lookup.
    drv(1'b0, 1'b0, 32'h0, 32'h44, 32'h40);
    chk("cold_pred_taken", {31'd0, PredTakenF}, 32'd0);
    chk("cold_pred_target", PredTargetF, 32'h44);
    tick();
    // Allocate 0x40 -> 0x100.
    drv(1'b1, 1'b1, 32'h100, 32'h44, 32'h44);
    chk("alloc_mispredict", {31'd0, MispredictD}, 32'd1);
    chk("alloc_redirect", RedirectPCD, 32'h100);
    tick();
    // Hit.
    drv(1'b0, 1'b0, 32'h0, 32'h48, 32'h40);
    chk("hit_pred_taken", {31'd0, PredTakenF}, 32'd1);
    chk("hit_pred_target", PredTargetF, 32'h100);
    chk("hit_bcnt", BranchCnt, 32'd1);
    chk("hit_mcnt", MispredCnt, 32'd1);
    chk("hit_nonbranch_misp", {31'd0, MispredictD}, 32'd0);
    tick();
    // Four taken updates: counter saturates at ST.
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b1, 32'h100, 32'h44, 32'h40);
      chk("taken_misp", {31'd0, MispredictD}, 32'd0);
      tick();
    end
    chk("sat_bcnt", BranchCnt, 32'd5);
    chk("sat_mcnt", MispredCnt, 32'd1);
    chk("sat_pred", {31'd0, PredTakenF}, 32'd1);
    // Not-taken #1: ST -> WT.
    drv(1'b1, 1'b0, 32'h100, 32'h44, 32'h40);
    chk("nt1_misp", {31'd0, MispredictD}, 32'd1);
    chk("nt1_redirect", RedirectPCD, 32'h44);
    tick();
    chk("wt_still_taken", {31'd0, PredTakenF}, 32'd1);
    chk("nt2_misp", {31'd0, MispredictD}, 32'd1);
    tick();
    chk("wnt_not_taken", {31'd0, PredTakenF}, 32'd0);
    chk("nt3_misp", {31'd0, MispredictD}, 32'd1);
    tick();
    chk("snt_not_taken", {31'd0, PredTakenF}, 32'd0);
    chk("snt_target", PredTargetF, 32'h44);
    chk("nt4_misp", {31'd0, MispredictD}, 32'd0);
    tick();
    // SNT + taken -> WNT.
    drv(1'b1, 1'b1, 32'h100, 32'h44, 32'h40);
    chk("snt_floor_pred", {31'd0, PredTakenF}, 32'd0);
    chk("pre_stall_bcnt", BranchCnt, 32'd9);
    chk("pre_stall_mcnt", MispredCnt, 32'd4);
    chk("t_after_snt_misp", {31'd0, MispredictD}, 32'd1);
    tick();
    // Stall three cycles with a taken branch: nothing may change.
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 32'h100, 32'h44, 32'h40);
      chk("stall_misp", {31'd0, MispredictD}, 32'd0);
      tick();
    end
    chk("stall_bcnt", BranchCnt, 32'd10);
    chk("stall_mcnt", MispredCnt, 32'd5);
    chk("stall_ctr_hold", {31'd0, PredTakenF}, 32'd0);
    // Release: WNT + taken -> WT.
    StallD = 1'b0;
    drv(1'b1, 1'b1, 32'h100, 32'h44, 32'h40);
    chk("unstall_misp", {31'd0, MispredictD}, 32'd1);
    tick();
    drv(1'b0, 1'b0, 32'h0, 32'h44, 32'h40);
    chk("wt_pred", {31'd0, PredTakenF}, 32'd1);
    tick();
    // Flush together with stall clears the taken prediction in decode.
    StallD = 1'b1; FlushD = 1'b1;
    drv(1'b0, 1'b0, 32'h0, 32'h44, 32'h40);
    chk("flush_stall_misp", {31'd0, MispredictD}, 32'd0);
    tick();
    StallD = 1'b0; FlushD = 1'b0;
    drv(1'b0, 1'b0, 32'h0, 32'h44, 32'h44);
    chk("flushed_misp", {31'd0, MispredictD}, 32'd0);
    chk("flushed_redirect", RedirectPCD, 32'h44);
    tick();
    // Same index, different tag: no hit.
    drv(1'b0, 1'b0, 32'h0, 32'h48, 32'h440);
    chk("tag_miss_pred", {31'd0, PredTakenF}, 32'd0);
    chk("tag_miss_target", PredTargetF, 32'h444);
    tick();
    // Same-tag alias: predicted taken, decodes as non-branch.
    drv(1'b0, 1'b0, 32'h0, 32'h444, 32'h40);
    chk("alias_pre_pred", {31'd0, PredTakenF}, 32'd1);
    chk("alias_pre_target", PredTargetF, 32'h100);
    tick();
    drv(1'b0, 1'b0, 32'h0, 32'h44, 32'h44);
    chk("alias_misp", {31'd0, MispredictD}, 32'd1);
    chk("alias_redirect", RedirectPCD, 32'h44);
    tick();
    drv(1'b0, 1'b0, 32'h0, 32'h48, 32'h40);
    chk("alias_invalid", {31'd0, PredTakenF}, 32'd0);
    chk("alias_inv_target", PredTargetF, 32'h44);
    chk("alias_mcnt", MispredCnt, 32'd7);
    chk("alias_bcnt", BranchCnt, 32'd11);
    tick();
    // Reset mid-operation with an update pending.
    drv(1'b1, 1'b1, 32'h100, 32'h44, 32'h44);
    chk("pre_reset_misp", {31'd0, MispredictD}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bcnt", BranchCnt, 32'd0);
    chk("async_rst_mcnt", MispredCnt, 32'd0);
    chk("async_rst_misp", {31'd0, MispredictD}, 32'd0);
    tick();
    rst_n = 1'b1;
    drv(1'b0, 1'b0, 32'h0, 32'h44, 32'h40);
    chk("post_rst_pred", {31'd0, PredTakenF}, 32'd0);
    chk("post_rst_bcnt", BranchCnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
